// File: rtl/mul_seq_pkg.sv
// Shared definitions for the radix-4 Booth multiply sequencer:
// FSM state encoding, Booth digit encoding and iteration-count helpers.
package mul_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // One radix-4 Booth digit retires two multiplier bits per step.
    function automatic int iter_of(input int width);
        return width / 2;
    endfunction

    localparam int ITER = iter_of(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_POS1 = 3'd1,
        DIG_POS2 = 3'd2,
        DIG_NEG1 = 3'd3,
        DIG_NEG2 = 3'd4
    } booth_digit_e;

    // Map a multiplier triplet {b[i+1], b[i], b[i-1]} to its Booth digit.
    function automatic booth_digit_e booth_decode(input logic [2:0] triplet);
        booth_digit_e digit;
        case (triplet)
            3'b000, 3'b111: digit = DIG_ZERO;
            3'b001, 3'b010: digit = DIG_POS1;
            3'b011:         digit = DIG_POS2;
            3'b100:         digit = DIG_NEG2;
            3'b101, 3'b110: digit = DIG_NEG1;
            default:        digit = DIG_ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Handshake/data bundle between the control unit (master) and the
// multiply sequencer (slave): start pulse, operands, busy/done, hi/lo.
interface mul_sequencer_if
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mul_sequencer_booth_recoder.sv
// Combinational radix-4 Booth recoder: turns a multiplier triplet and the
// (already aligned) multiplicand into the signed addend for this step.
// Negation is plain two's complement on 2*WIDTH bits, so the most-negative
// multiplicand wraps exactly as the modular accumulator expects.
module booth_recoder
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]         i_triplet,
    input  logic [2*WIDTH-1:0] i_mcand,
    output logic [2*WIDTH-1:0] o_addend
);

    logic [2*WIDTH-1:0] w_mcand_x2;

    assign w_mcand_x2 = {i_mcand[2*WIDTH-2:0], 1'b0};

    // Select 0, +/-mcand or +/-2*mcand from the decoded digit.
    always_comb begin
        o_addend = '0;
        case (booth_decode(i_triplet))
            DIG_ZERO: o_addend = '0;
            DIG_POS1: o_addend = i_mcand;
            DIG_POS2: o_addend = w_mcand_x2;
            DIG_NEG1: o_addend = (~i_mcand) + {{(2*WIDTH-1){1'b0}}, 1'b1};
            DIG_NEG2: o_addend = (~w_mcand_x2) + {{(2*WIDTH-1){1'b0}}, 1'b1};
            default:  o_addend = '0;
        endcase
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle signed WIDTH x WIDTH multiplier: radix-4 Booth, one partial
// product per clock into a 2*WIDTH accumulator. start is honoured only in
// IDLE; busy covers RUN and DONE; done pulses for one cycle with hi/lo valid.
// Optional build macro MUL_SEQ_EARLY_TERM_EN: stop as soon as the remaining
// multiplier bits are all 0 or all 1 (same result, shorter latency).
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clock,
    input  logic           clear,
    mul_sequencer_if.slave bus
);

    localparam int N_ITER = iter_of(WIDTH);
    localparam int CNT_W  = $clog2(N_ITER) + 1;

    mul_state_e         r_state;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH:0]     r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH:0]     w_mplier_next;
    logic               w_count_last;
    logic               w_early;
    logic               w_last;

    booth_recoder #(
        .WIDTH (WIDTH)
    ) u_recoder (
        .i_triplet (r_mplier[2:0]),
        .i_mcand   (r_mcand),
        .o_addend  (w_addend)
    );

    assign w_acc_next    = r_acc + w_addend;
    assign w_mplier_next = $signed(r_mplier) >>> 2;
    assign w_count_last  = (r_count == CNT_W'(N_ITER - 1));

`ifdef MUL_SEQ_EARLY_TERM_EN
    // Remaining bits all equal means every remaining digit is zero.
    assign w_early = (w_mplier_next == '0) || (&w_mplier_next);
`else
    assign w_early = 1'b0;
`endif

    assign w_last = w_count_last || w_early;

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mcand  <= {{WIDTH{bus.op_a[WIDTH-1]}}, bus.op_a};
                        r_mplier <= {bus.op_b, 1'b0};
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= {r_mcand[2*WIDTH-3:0], 2'b00};
                    r_mplier <= w_mplier_next;
                    r_count  <= r_count + CNT_W'(1);
                    r_busy   <= 1'b1;
                    if (w_last) begin
                        r_hi    <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_lo    <= w_acc_next[WIDTH-1:0];
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Single done cycle; start is deliberately not looked at here.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: expected products are pushed to a
// scoreboard when a multiply is launched and popped when done pulses.
module tb_mul_sequencer;
    import mul_seq_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic clock = 1'b0;
    logic clear;

    mul_sequencer_if #(.WIDTH(W)) bus ();

    mul_sequencer #(.WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[W-1]}}, a};
        sb = {{32{b[W-1]}}, b};
        return sa * sb;
    endfunction

    // Number of Booth steps expected for multiplier b in this build.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
        logic signed [W-1:0] t;
        for (int k = 1; k <= ITER; k++) begin
            t = $signed(b) >>> (2 * k - 1);
            if (t == '0 || t == '1) return k;
        end
        return ITER;
`else
        return ITER;
`endif
    endfunction

    // Present operands with start, take the accepting edge, then scramble inputs.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        if (push) sb_q.push_back(model(a, b));
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
    endtask

    // Wait (bounded) for done; check latency, busy, and the scoreboard result.
    task automatic finish_op(input string tag, input int lat);
        int          edges = 0;
        bit          seen = 1'b0;
        bit          busy_ok = 1'b1;
        logic [63:0] exp;
        while (edges < 40 && !seen) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (bus.done) seen = 1'b1;
            else if (!bus.busy) busy_ok = 1'b0;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(edges), 64'(lat));
        check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_product"}, {bus.hi, bus.lo}, exp);
        end
    endtask

    // One edge after the done cycle the sequencer must be idle.
    task automatic idle_check(input string tag);
        @(posedge clock);
        @(negedge clock);
        check({tag, "_done_low"}, 64'(bus.done), 64'd0);
        check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    endtask

    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           any_done;
    bit           any_busy;

    initial begin
        clear     = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        clear = 1'b0;

        // Test-plan vectors, including the most-negative operand.
        launch(32'd7, 32'hFFFFFFFD, 1'b1);
        finish_op("m7xm3", exp_lat(32'hFFFFFFFD));
        check("m7xm3_hi", 64'(bus.hi), 64'h00000000FFFFFFFF);
        check("m7xm3_lo", 64'(bus.lo), 64'h00000000FFFFFFEB);
        idle_check("m7xm3");

        launch(32'h80000000, 32'h80000000, 1'b1);
        finish_op("minxmin", exp_lat(32'h80000000));
        check("minxmin_hi", 64'(bus.hi), 64'h0000000040000000);
        idle_check("minxmin");

        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        finish_op("m1xm1", exp_lat(32'hFFFFFFFF));
        idle_check("m1xm1");

        launch(32'h7FFFFFFF, 32'd2, 1'b1);
        finish_op("maxx2", exp_lat(32'd2));
        check("maxx2_lo", 64'(bus.lo), 64'h00000000FFFFFFFE);

        // start raised during the done cycle must be ignored, then accepted in IDLE.
        bus.start = 1'b1;
        bus.op_a  = 32'd11;
        bus.op_b  = 32'hFFFFFFF3;
        sb_q.push_back(model(32'd11, 32'hFFFFFFF3));
        idle_check("start_in_done");
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        finish_op("after_done", exp_lat(32'hFFFFFFF3));
        idle_check("after_done");

        // Abort: 6*7 running, ignored 9*9 start at step 5, clear at step 10.
        any_done = 1'b0;
        launch(32'd6, 32'd7, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) begin
                bus.start = 1'b1;
                bus.op_a  = 32'd9;
                bus.op_b  = 32'd9;
            end else if (i == 6) begin
                bus.start = 1'b0;
            end else if (i == 10) begin
                clear = 1'b1;
            end
            @(posedge clock);
            #1;
            if (bus.done) any_done = 1'b1;
        end
        clear = 1'b0;
        @(negedge clock);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        any_busy = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (bus.done) any_done = 1'b1;
            if (bus.busy) any_busy = 1'b1;
        end
        check("abort_no_done", 64'(any_done), 64'd0);
        check("abort_no_queue", 64'(any_busy), 64'd0);
        launch(32'd9, 32'd9, 1'b1);
        finish_op("m9x9", exp_lat(32'd9));
        check("m9x9_lo", 64'(bus.lo), 64'd81);
        idle_check("m9x9");

        // Short-multiplier cases (early termination when enabled).
        launch(32'd5, 32'd3, 1'b1);
        finish_op("m5x3", exp_lat(32'd3));
        check("m5x3_lo", 64'(bus.lo), 64'd15);
        idle_check("m5x3");

        launch(32'd5, 32'd0, 1'b1);
        finish_op("m5x0", exp_lat(32'd0));
        idle_check("m5x0");

        // hi/lo hold between operations.
        repeat (3) @(negedge clock);
        check("hold_lo", 64'(bus.lo), 64'd0);

        // A few random operands.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 4) rb = 32'h00000040;
            if (i == 5) rb = 32'hFFFFFF80;
            launch(ra, rb, 1'b1);
            finish_op($sformatf("rnd%0d", i), exp_lat(rb));
            idle_check($sformatf("rnd%0d", i));
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
